// File: rtl/mem_port_arbiter.sv
// Arbitrates IF fetches and MEM data accesses onto one variable-latency memory port.
// Request-to-done is >=3 cycles; the losing or waiting port stalls until its done pulse.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_DSTREAK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic [DATA_W-1:0]     i_rdata,
  output logic                  i_done,
  output logic                  stall_if,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_wstrb,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_done,
  output logic                  stall_mem,
  output logic                  mem_valid,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  input  logic                  mem_ready,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [1:0]            owner
);

  localparam int CNT_W = $clog2(MAX_DSTREAK + 1);
  localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_DSTREAK);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] streak_q;
  logic             grant_i;
  logic             grant_d;
  logic             complete;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d = D_BUSY;
        end else if (grant_i) begin
          state_d = I_BUSY;
        end
      end
      I_BUSY, D_BUSY: begin
        if (mem_ready) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Data wins unless it has already taken MAX_DSTREAK grants in a row over a waiting fetch.
  always_comb begin
    grant_d  = 1'b0;
    grant_i  = 1'b0;
    complete = 1'b0;
    owner    = state_q;
    if (state_q == IDLE) begin
      grant_d = d_req && (!i_req || (streak_q < STREAK_MAX));
      grant_i = i_req && !grant_d;
    end
    if ((state_q == I_BUSY) || (state_q == D_BUSY)) begin
      complete = mem_ready;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      streak_q  <= '0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      if (grant_d) begin
        mem_valid <= 1'b1;
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        mem_wstrb <= d_we ? d_wstrb : '0;
        if (!i_req) begin
          streak_q <= '0;
        end else if (streak_q != STREAK_MAX) begin
          streak_q <= streak_q + CNT_W'(1);
        end
      end else if (grant_i) begin
        mem_valid <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= i_addr;
        mem_wdata <= '0;
        mem_wstrb <= '0;
        streak_q  <= '0;
      end
      if (complete) begin
        mem_valid <= 1'b0;
        if (state_q == I_BUSY) begin
          i_done  <= 1'b1;
          i_rdata <= mem_rdata;
        end else begin
          d_done <= 1'b1;
          if (!mem_we) begin
            d_rdata <= mem_rdata;
          end
        end
      end
    end
  end

  assign stall_if  = i_req & ~i_done;
  assign stall_mem = d_req & ~d_done;

endmodule
